// File: rtl/load_store_unit.sv
// Load/store unit bridging a core request to a word-organised memory.
// Sub-word stores are done as read-modify-write; misaligned or out-of-range requests fault.
module load_store_unit #(
  parameter int unsigned MEMORY_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        access_fault,
  output logic [31:0] rdata,
  output logic        memory_read,
  output logic        memory_write,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q;
  logic        fault_in;
  logic        accept;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] merged;

  assign accept = (state_q == StIdle) && start;

  always_comb begin
    fault_in = 1'b0;
    if (funct3 == 3'b011 || funct3[2:1] == 2'b11) fault_in = 1'b1;
    if (store && funct3[2]) fault_in = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0]) fault_in = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) fault_in = 1'b1;
    if (addr >= MEMORY_SIZE) fault_in = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (fault_in) state_d = StDone;
          else if (store && funct3[1:0] == 2'b10) state_d = StWrite;
          else state_d = StRead;
        end
      end
      StRead:  state_d = store_q ? StWrite : StDone;
      StWrite: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Load extraction works on the live read_data so rdata lands on the READ->DONE edge.
  assign rd_byte = read_data[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = addr_q[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    rdata_d = rdata_q;
    if (state_q == StRead && !store_q) begin
      case (funct3_q)
        3'b000:  rdata_d = {{24{rd_byte[7]}}, rd_byte};
        3'b001:  rdata_d = {{16{rd_half[15]}}, rd_half};
        3'b010:  rdata_d = read_data;
        3'b100:  rdata_d = {24'd0, rd_byte};
        3'b101:  rdata_d = {16'd0, rd_half};
        default: rdata_d = rdata_q;
      endcase
    end
  end

  always_comb begin
    merged = word_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      word_q   <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept) begin
        store_q  <= store;
        funct3_q <= funct3;
        addr_q   <= addr;
        wdata_q  <= wdata;
        fault_q  <= fault_in;
      end
      if (state_q == StRead) word_q <= read_data;
    end
  end

  assign busy         = state_q != StIdle;
  assign done         = state_q == StDone;
  assign access_fault = (state_q == StDone) && fault_q;
  assign memory_read  = state_q == StRead;
  assign memory_write = state_q == StWrite;
  assign address      = {addr_q[31:2], 2'b00};
  assign write_data   = merged;
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, access_fault, memory_read, memory_write;
  logic [31:0] rdata, address, write_data, read_data;

  logic [31:0] mem [0:1023];
  int passed = 0;
  int total = 0;

  load_store_unit #(.MEMORY_SIZE(4096)) dut (
    .clk(clk), .reset(reset), .start(start), .store(store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .access_fault(access_fault),
    .rdata(rdata), .memory_read(memory_read), .memory_write(memory_write),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  assign read_data = mem[address[11:2]];
  always @(posedge clk) if (memory_write) mem[address[11:2]] <= write_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issues one request, scrambles inputs while busy, and waits (bounded) for done.
  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output int lat, output int nrd, output int nwr,
                     output logic flt, output logic [31:0] wseen, output logic ovl);
    @(negedge clk);
    start = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    start = 1'b0; store = ~st; funct3 = ~f3; addr = 32'h0000_0FFC; wdata = ~wd;
    lat = 0; nrd = 0; nwr = 0; flt = 1'b0; wseen = 32'hDEAD_BEEF; ovl = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (memory_read) nrd++;
      if (memory_write) begin nwr++; wseen = write_data; end
      if (memory_read && memory_write) ovl = 1'b1;
      if (done) begin flt = access_fault; break; end
    end
    if (!done) lat = 99;
  endtask

  int lat, nrd, nwr, ndone;
  logic flt, ovl;
  logic [31:0] ws;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[4] = 32'h8899AABB;

    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, access_fault}, 32'd0);
    check("rst_mrd", {31'd0, memory_read}, 32'd0);
    check("rst_mwr", {31'd0, memory_write}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_wdata", write_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run(1'b0, 3'b000, 32'h13, 32'h0, lat, nrd, nwr, flt, ws, ovl);
    check("lb_lat", lat, 2);
    check("lb_rdata", rdata, 32'hFFFFFF88);
    check("lb_fault", {31'd0, flt}, 32'd0);
    check("lb_nrd", nrd, 1);
    check("lb_nwr", nwr, 0);

    run(1'b0, 3'b100, 32'h13, 32'h0, lat, nrd, nwr, flt, ws, ovl);
    check("lbu_rdata", rdata, 32'h00000088);

    run(1'b0, 3'b001, 32'h12, 32'h0, lat, nrd, nwr, flt, ws, ovl);
    check("lh_rdata", rdata, 32'hFFFF8899);

    run(1'b0, 3'b101, 32'h10, 32'h0, lat, nrd, nwr, flt, ws, ovl);
    check("lhu_rdata", rdata, 32'h0000AABB);

    run(1'b0, 3'b010, 32'h10, 32'h0, lat, nrd, nwr, flt, ws, ovl);
    check("lw_rdata", rdata, 32'h8899AABB);
    check("lw_nrd", nrd, 1);
    check("lw_lat", lat, 2);

    run(1'b1, 3'b000, 32'h11, 32'h000000CC, lat, nrd, nwr, flt, ws, ovl);
    check("sb_lat", lat, 3);
    check("sb_nrd", nrd, 1);
    check("sb_nwr", nwr, 1);
    check("sb_wdata", ws, 32'h8899CCBB);
    check("sb_mem", mem[4], 32'h8899CCBB);
    check("sb_rdata_kept", rdata, 32'h8899AABB);
    check("sb_overlap", {31'd0, ovl}, 32'd0);

    run(1'b1, 3'b010, 32'h10, 32'h12345678, lat, nrd, nwr, flt, ws, ovl);
    check("sw_lat", lat, 2);
    check("sw_nrd", nrd, 0);
    check("sw_nwr", nwr, 1);
    check("sw_mem", mem[4], 32'h12345678);

    run(1'b1, 3'b001, 32'h12, 32'h0000BEEF, lat, nrd, nwr, flt, ws, ovl);
    check("sh_lat", lat, 3);
    check("sh_mem", mem[4], 32'hBEEF5678);
    check("sh_fault", {31'd0, flt}, 32'd0);

    run(1'b0, 3'b010, 32'h02, 32'h0, lat, nrd, nwr, flt, ws, ovl);
    check("flw_lat", lat, 1);
    check("flw_fault", {31'd0, flt}, 32'd1);
    check("flw_mem_en", nrd + nwr, 0);
    check("flw_rdata", rdata, 32'h8899AABB);

    run(1'b1, 3'b000, 32'd4096, 32'h55, lat, nrd, nwr, flt, ws, ovl);
    check("fsb_lat", lat, 1);
    check("fsb_fault", {31'd0, flt}, 32'd1);
    check("fsb_mem_en", nrd + nwr, 0);

    run(1'b0, 3'b011, 32'h10, 32'h0, lat, nrd, nwr, flt, ws, ovl);
    check("f011_lat", lat, 1);
    check("f011_fault", {31'd0, flt}, 32'd1);
    check("f011_rdata", rdata, 32'h8899AABB);

    run(1'b1, 3'b100, 32'h10, 32'h0, lat, nrd, nwr, flt, ws, ovl);
    check("fstu_fault", {31'd0, flt}, 32'd1);
    run(1'b0, 3'b001, 32'h11, 32'h0, lat, nrd, nwr, flt, ws, ovl);
    check("flh_odd_fault", {31'd0, flt}, 32'd1);
    check("fault_mem_kept", mem[4], 32'hBEEF5678);

    // start held for 9 edges: LW takes 3 cycles per request, so exactly 3 dones.
    @(negedge clk);
    start = 1'b1; store = 1'b0; funct3 = 3'b010; addr = 32'h10;
    ndone = 0; nrd = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (memory_read) nrd++;
    end
    start = 1'b0;
    check("b2b_dones", ndone, 3);
    check("b2b_reads", nrd, 3);
    check("b2b_rdata", rdata, 32'hBEEF5678);
    @(negedge clk);
    check("b2b_idle", {31'd0, busy}, 32'd0);

    @(negedge clk);
    start = 1'b1; store = 1'b1; funct3 = 3'b001; addr = 32'h10; wdata = 32'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rstw_in_write", {31'd0, memory_write}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rstw_mwr_drop", {31'd0, memory_write}, 32'd0);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rstw_no_done", ndone, 0);
    check("rstw_mem", mem[4], 32'hBEEF5678);
    check("rstw_rdata", rdata, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
